// File: rtl/multi_tap_corr_channel.sv
// N-tap code correlator channel: code/carrier wipe-off, per-tap I/Q integrate-and-dump,
// shared-squarer tap power on a valid/ready stream. Define CORR_SAT_EN for saturating accumulators.
module multi_tap_corr_channel #(
  parameter int N_TAPS  = 3,
  parameter int SPACING = 2,
  parameter int IN_W    = 4,
  parameter int ACC_W   = 24,
  parameter int INT_LEN = 2046,
  localparam int TAP_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   sample_valid,
  input  logic signed [IN_W-1:0] sample,
  input  logic                   code_in,
  input  logic                   carr_cos,
  input  logic                   carr_sin,
  input  logic                   epoch,
  output logic                   pwr_valid,
  input  logic                   pwr_ready,
  output logic [2*ACC_W-1:0]     pwr_data,
  output logic [TAP_W-1:0]       pwr_tap,
  output logic                   pwr_last,
  output logic                   overrun
);

  localparam int DL_LEN = (N_TAPS - 1) * SPACING + 1;
  localparam int CNT_W  = (INT_LEN > 1) ? $clog2(INT_LEN) : 1;

  typedef enum logic [1:0] {IDLE, SQ_I, SQ_Q, OUT} state_t;

  logic [DL_LEN-1:0]        code_line;
  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc_i    [N_TAPS];
  logic signed [ACC_W-1:0]  acc_q    [N_TAPS];
  logic signed [ACC_W-1:0]  acc_i_nxt[N_TAPS];
  logic signed [ACC_W-1:0]  acc_q_nxt[N_TAPS];
  logic signed [ACC_W-1:0]  dump_i   [N_TAPS];
  logic signed [ACC_W-1:0]  dump_q   [N_TAPS];
  logic signed [IN_W:0]     s_ext;
  logic                     last_sample;
  logic                     snap;
  logic                     take;
  logic                     last_tap;

  state_t                   state, state_nxt;
  logic [TAP_W-1:0]         tap_idx, tap_nxt;
  logic                     pend, pend_nxt;
  logic [2*ACC_W-1:0]       pwr_acc;
  logic signed [ACC_W-1:0]  sq_op;
  logic signed [2*ACC_W-1:0] sq_wide;

  // Widen before negating so that -(-2^(IN_W-1)) stays exact.
  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [IN_W:0]    s,
    input logic                    neg
  );
    logic signed [IN_W:0]  term;
    logic signed [ACC_W:0] sum;
    term = neg ? -s : s;
    sum  = (ACC_W+1)'(acc) + (ACC_W+1)'(term);
`ifdef CORR_SAT_EN
    if (sum[ACC_W] != sum[ACC_W-1])
      return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return sum[ACC_W-1:0];
`else
    return sum[ACC_W-1:0];
`endif
  endfunction

  assign s_ext       = {sample[IN_W-1], sample};
  assign last_sample = sample_valid && (cnt == CNT_W'(INT_LEN - 1));
  assign snap        = last_sample && !epoch;

  // The code history survives epochs; only sample_valid moves it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)              code_line <= '0;
    else if (sample_valid) code_line <= {code_line[DL_LEN-2:0], code_in};
  end

  always_comb begin
    for (int k = 0; k < N_TAPS; k++) begin
      acc_i_nxt[k] = acc_add(acc_i[k], s_ext, carr_cos ^ code_line[k*SPACING]);
      acc_q_nxt[k] = acc_add(acc_q[k], s_ext, carr_sin ^ code_line[k*SPACING]);
    end
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values;
  // blocking assignments here would make the result depend on statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
      for (int k = 0; k < N_TAPS; k++) begin
        acc_i[k] <= '0;
        acc_q[k] <= '0;
      end
    end else if (epoch || last_sample) begin
      cnt <= '0;
      for (int k = 0; k < N_TAPS; k++) begin
        acc_i[k] <= '0;
        acc_q[k] <= '0;
      end
    end else if (sample_valid) begin
      cnt <= cnt + 1'b1;
      for (int k = 0; k < N_TAPS; k++) begin
        acc_i[k] <= acc_i_nxt[k];
        acc_q[k] <= acc_q_nxt[k];
      end
    end
  end

  // NOTE: the dump registers are a small register array, not a RAM, so they get an
  // async reset like any other flop; a block-RAM array would be left unreset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < N_TAPS; k++) begin
        dump_i[k] <= '0;
        dump_q[k] <= '0;
      end
    end else if (take) begin
      for (int k = 0; k < N_TAPS; k++) begin
        dump_i[k] <= acc_i_nxt[k];
        dump_q[k] <= acc_q_nxt[k];
      end
    end
  end

  assign last_tap = (tap_idx == TAP_W'(N_TAPS - 1));

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    tap_nxt   = tap_idx;
    pend_nxt  = pend;
    take      = snap && (((state == IDLE) && !pend) ||
                         ((state == OUT) && pwr_ready && last_tap));
    unique case (state)
      IDLE: if (pend) begin
        state_nxt = SQ_I;
        tap_nxt   = '0;
        pend_nxt  = 1'b0;
      end
      SQ_I: state_nxt = SQ_Q;
      SQ_Q: state_nxt = OUT;
      OUT: if (pwr_ready) begin
        if (last_tap) begin
          state_nxt = IDLE;
          tap_nxt   = '0;
        end else begin
          state_nxt = SQ_I;
          tap_nxt   = tap_idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take) pend_nxt = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      tap_idx <= '0;
      pend    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      tap_idx <= tap_nxt;
      pend    <= pend_nxt;
      if (snap && !take) overrun <= 1'b1;
    end
  end

  // One squarer serves both halves of every tap: I in SQ_I, Q in SQ_Q.
  always_comb begin
    sq_op   = (state == SQ_Q) ? dump_q[tap_idx] : dump_i[tap_idx];
    sq_wide = (2*ACC_W)'(sq_op) * (2*ACC_W)'(sq_op);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                pwr_acc <= '0;
    else if (state == SQ_I)  pwr_acc <= $unsigned(sq_wide);
    else if (state == SQ_Q)  pwr_acc <= pwr_acc + $unsigned(sq_wide);
  end

  assign pwr_valid = (state == OUT);
  assign pwr_data  = pwr_acc;
  assign pwr_tap   = tap_idx;
  assign pwr_last  = pwr_valid && last_tap;

endmodule
